// File: rtl/ext_mem_loader.sv
// Host-side initiator for the CPU external memory ports.
// Loads imem then dmem from an input stream, runs the CPU for a fixed budget, then streams a dmem window out.
module ext_mem_loader #(
   parameter int unsigned IMEM_WORDS = 64,
   parameter int unsigned DMEM_WORDS = 16,
   parameter int unsigned RUN_CYCLES = 256,
   parameter logic [31:0] DUMP_BASE  = 32'd0,
   parameter int unsigned DUMP_WORDS = 16
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready,
   output logic        cpu_enable,
   output logic [31:0] addr_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [31:0] wdata_ext,
   input  logic [31:0] rdata_ext,
   output logic [31:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   output logic [31:0] wdata_ext_2,
   input  logic [31:0] rdata_ext_2
);

   localparam logic [31:0] LAST_I   = 32'(IMEM_WORDS) - 32'd1;
   localparam logic [31:0] LAST_D   = 32'(DMEM_WORDS) - 32'd1;
   localparam logic [31:0] LAST_RUN = 32'(RUN_CYCLES) - 32'd1;
   localparam logic [31:0] LAST_RD  = 32'(DUMP_WORDS) - 32'd1;

   typedef enum logic [2:0] {
      IDLE, LOAD_I, LOAD_D, RUN, RD, RD_WAIT, OUT, DONE
   } state_e;

   state_e      state_q, state_d;
   state_e      after_start, after_i, after_d, after_run;
   logic [31:0] cnt_q, cnt_d;
   logic        wen_q, wen_d, wen2_q, wen2_d, ren2_q, ren2_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [31:0] addr2_q, addr2_d, wdata2_q, wdata2_d;
   logic        cpu_en_q, cpu_en_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_data_q, out_data_d;
   logic        unused_rdata_c;

   // Phase skipping: each phase chains to the next one with a non-zero count
   always_comb begin
      after_run   = (DUMP_WORDS != 0) ? RD     : DONE;
      after_d     = (RUN_CYCLES != 0) ? RUN    : after_run;
      after_i     = (DMEM_WORDS != 0) ? LOAD_D : after_d;
      after_start = (IMEM_WORDS != 0) ? LOAD_I : after_i;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wen_d       = 1'b0;
      wen2_d      = 1'b0;
      ren2_d      = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      addr2_d     = addr2_q;
      wdata2_d    = wdata2_q;
      cpu_en_d    = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = after_start;
               cnt_d   = 32'd0;
            end
         end
         LOAD_I: begin
            if (in_valid) begin
               wen_d   = 1'b1;
               addr_d  = {cnt_q[29:0], 2'b00};
               wdata_d = in_data;
               if (cnt_q == LAST_I) begin
                  state_d = after_i;
                  cnt_d   = 32'd0;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
         end
         LOAD_D: begin
            if (in_valid) begin
               wen2_d   = 1'b1;
               addr2_d  = {cnt_q[29:0], 2'b00};
               wdata2_d = in_data;
               if (cnt_q == LAST_D) begin
                  state_d = after_d;
                  cnt_d   = 32'd0;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
         end
         RUN: begin
            cpu_en_d = 1'b1;
            if (cnt_q == LAST_RUN) begin
               state_d = after_run;
               cnt_d   = 32'd0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         RD: begin
            // Read was deferred on entry if the final dmem write occupied the port
            if (ren2_q) begin
               state_d = RD_WAIT;
            end else begin
               ren2_d  = 1'b1;
               addr2_d = DUMP_BASE + {cnt_q[29:0], 2'b00};
            end
         end
         RD_WAIT: begin
            out_data_d  = rdata_ext_2;
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (cnt_q == LAST_RD) begin
                  state_d = DONE;
                  cnt_d   = 32'd0;
               end else begin
                  state_d = RD;
                  cnt_d   = cnt_q + 32'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Issue the read on RD entry so rdata lands while in RD_WAIT
      if (state_d == RD && state_q != RD && !wen2_d) begin
         ren2_d  = 1'b1;
         addr2_d = DUMP_BASE + {cnt_d[29:0], 2'b00};
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 32'd0;
         wen_q       <= 1'b0;
         wen2_q      <= 1'b0;
         ren2_q      <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         addr2_q     <= 32'd0;
         wdata2_q    <= 32'd0;
         cpu_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wen_q       <= wen_d;
         wen2_q      <= wen2_d;
         ren2_q      <= ren2_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         addr2_q     <= addr2_d;
         wdata2_q    <= wdata2_d;
         cpu_en_q    <= cpu_en_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign busy           = (state_q != IDLE) && (state_q != DONE);
   assign done           = (state_q == DONE);
   assign in_ready       = (state_q == LOAD_I) || (state_q == LOAD_D);
   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign cpu_enable     = cpu_en_q;
   assign addr_ext       = addr_q;
   assign wen_ext        = wen_q;
   assign ren_ext        = 1'b0;
   assign wdata_ext      = wdata_q;
   assign addr_ext_2     = addr2_q;
   assign wen_ext_2      = wen2_q;
   assign ren_ext_2      = ren2_q;
   assign wdata_ext_2    = wdata2_q;
   assign unused_rdata_c = ^rdata_ext;

endmodule
